// File: rtl/spi_storage_pkg.sv
// spi_storage_pkg: opcodes, FSM states and status-register layout for the SPI storage responder
package spi_storage_pkg;

   localparam logic [7:0] OP_READ    = 8'h03;
   localparam logic [7:0] OP_PROGRAM = 8'h02;
   localparam logic [7:0] OP_RDSR    = 8'h05;
   localparam logic [7:0] OP_WREN    = 8'h06;
   localparam logic [7:0] OP_WRDI    = 8'h04;

   localparam int SR_WEL = 1;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CMD,
      ST_ADDR,
      ST_READ_DATA,
      ST_WRITE_DATA,
      ST_STATUS,
      ST_IGNORE
   } spi_resp_state_e;

   function automatic logic [7:0] status_byte(input logic wel);
      logic [7:0] s;
      s = 8'h00;
      s[SR_WEL] = wel;
      return s;
   endfunction

endpackage

// File: rtl/spi_storage_responder_pin_sync.sv
// spi_pin_sync: synchronizes the SPI pins into clk and produces registered edge strobes
module spi_pin_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic sck_i,
   input  logic cs_n_i,
   input  logic mosi_i,
   output logic sck_rise_o,
   output logic sck_fall_o,
   output logic cs_n_s_o,
   output logic cs_fall_o,
   output logic cs_rise_o,
   output logic mosi_s_o
);

   logic [SYNC_STAGES-1:0] sck_q, cs_q, mosi_q;
   logic sck_prev_q, cs_prev_q;
   logic sck_rise_q, sck_fall_q, cs_fall_q, cs_rise_q, cs_n_s_q, mosi_s_q;

   // Shift pins through the synchronizer; strobes compare the last stage with its previous value
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sck_q      <= '0;
         cs_q       <= '1;
         mosi_q     <= '0;
         sck_prev_q <= 1'b0;
         cs_prev_q  <= 1'b1;
         sck_rise_q <= 1'b0;
         sck_fall_q <= 1'b0;
         cs_fall_q  <= 1'b0;
         cs_rise_q  <= 1'b0;
         cs_n_s_q   <= 1'b1;
         mosi_s_q   <= 1'b0;
      end else begin
         sck_q      <= SYNC_STAGES'({sck_q, sck_i});
         cs_q       <= SYNC_STAGES'({cs_q, cs_n_i});
         mosi_q     <= SYNC_STAGES'({mosi_q, mosi_i});
         sck_prev_q <= sck_q[SYNC_STAGES-1];
         cs_prev_q  <= cs_q[SYNC_STAGES-1];
         sck_rise_q <= sck_q[SYNC_STAGES-1] & ~sck_prev_q;
         sck_fall_q <= ~sck_q[SYNC_STAGES-1] & sck_prev_q;
         cs_fall_q  <= ~cs_q[SYNC_STAGES-1] & cs_prev_q;
         cs_rise_q  <= cs_q[SYNC_STAGES-1] & ~cs_prev_q;
         cs_n_s_q   <= cs_q[SYNC_STAGES-1];
         mosi_s_q   <= mosi_q[SYNC_STAGES-1];
      end
   end

   assign sck_rise_o = sck_rise_q;
   assign sck_fall_o = sck_fall_q;
   assign cs_fall_o  = cs_fall_q;
   assign cs_rise_o  = cs_rise_q;
   assign cs_n_s_o   = cs_n_s_q;
   assign mosi_s_o   = mosi_s_q;

endmodule

// File: rtl/spi_storage_responder.sv
// spi_storage_responder: SPI mode-0 flash-like target serving READ/PROGRAM/RDSR/WREN/WRDI over a byte memory port
module spi_storage_responder
   import spi_storage_pkg::*;
#(
   parameter int ADDR_W      = 16,
   parameter int SYNC_STAGES = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              spi_cs_n,
   input  logic              spi_sck,
   input  logic              spi_mosi,
   output logic              spi_miso,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_re,
   input  logic [7:0]        mem_rdata,
   output logic              mem_we,
   output logic [7:0]        mem_wdata,
   output logic              cmd_error
);

   logic sck_rise, sck_fall, cs_n_s, cs_fall, cs_rise, mosi_s;

   spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .clk        (clk),
      .rst        (rst),
      .sck_i      (spi_sck),
      .cs_n_i     (spi_cs_n),
      .mosi_i     (spi_mosi),
      .sck_rise_o (sck_rise),
      .sck_fall_o (sck_fall),
      .cs_n_s_o   (cs_n_s),
      .cs_fall_o  (cs_fall),
      .cs_rise_o  (cs_rise),
      .mosi_s_o   (mosi_s)
   );

   spi_resp_state_e   state_q, state_d;
   logic [4:0]        cnt_q, cnt_d;
   logic [6:0]        rx_q, rx_d;
   logic [7:0]        tx_q, tx_d;
   logic [7:0]        op_q, op_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [7:0]        wdata_q, wdata_d;
   logic              wel_q, wel_d;
   logic              miso_q, miso_d;
   logic              re_q, re_d;
   logic              we_q, we_d;
   logic              load_q, load_d;
   logic              err_q, err_d;
   logic [7:0]        byte_in;

   // State and datapath registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         rx_q    <= '0;
         tx_q    <= '0;
         op_q    <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
         wel_q   <= 1'b0;
         miso_q  <= 1'b0;
         re_q    <= 1'b0;
         we_q    <= 1'b0;
         load_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rx_q    <= rx_d;
         tx_q    <= tx_d;
         op_q    <= op_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         wel_q   <= wel_d;
         miso_q  <= miso_d;
         re_q    <= re_d;
         we_q    <= we_d;
         load_q  <= load_d;
         err_q   <= err_d;
      end
   end

   // Transaction FSM: bit counting, opcode decode, memory strobes and MISO shifting
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      rx_d    = rx_q;
      tx_d    = tx_q;
      op_d    = op_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      wel_d   = wel_q;
      miso_d  = miso_q;
      re_d    = 1'b0;
      we_d    = 1'b0;
      err_d   = 1'b0;
      load_d  = re_q;
      byte_in = {rx_q, mosi_s};
      if (load_q) tx_d = mem_rdata;
      if (we_q) addr_d = addr_q + ADDR_W'(1);
      if (cs_rise) begin
         state_d = ST_IDLE;
         cnt_d   = '0;
         miso_d  = 1'b0;
         op_d    = '0;
         if (op_q == OP_PROGRAM) wel_d = 1'b0;
      end else if (cs_fall && state_q == ST_IDLE) begin
         state_d = ST_CMD;
         cnt_d   = '0;
         miso_d  = 1'b0;
      end else if (!cs_n_s) begin
         if (sck_fall && (state_q == ST_READ_DATA || state_q == ST_STATUS)) begin
            miso_d = tx_q[7];
            tx_d   = {tx_q[6:0], 1'b0};
         end
         if (sck_rise) begin
            rx_d  = byte_in[6:0];
            cnt_d = cnt_q + 5'd1;
            case (state_q)
               ST_CMD: if (cnt_q == 5'd7) begin
                  cnt_d = '0;
                  op_d  = byte_in;
                  case (byte_in)
                     OP_READ, OP_PROGRAM: state_d = ST_ADDR;
                     OP_RDSR: begin
                        state_d = ST_STATUS;
                        tx_d    = status_byte(wel_q);
                     end
                     OP_WREN: begin
                        wel_d   = 1'b1;
                        state_d = ST_IGNORE;
                     end
                     OP_WRDI: begin
                        wel_d   = 1'b0;
                        state_d = ST_IGNORE;
                     end
                     default: begin
                        err_d   = 1'b1;
                        state_d = ST_IGNORE;
                     end
                  endcase
               end
               ST_ADDR: begin
                  addr_d = ADDR_W'({addr_q, mosi_s});
                  if (cnt_q == 5'd23) begin
                     cnt_d   = '0;
                     re_d    = op_q == OP_READ;
                     state_d = (op_q == OP_READ) ? ST_READ_DATA : ST_WRITE_DATA;
                  end
               end
               ST_READ_DATA: if (cnt_q == 5'd7) begin
                  cnt_d  = '0;
                  addr_d = addr_q + ADDR_W'(1);
                  re_d   = 1'b1;
               end
               ST_WRITE_DATA: if (cnt_q == 5'd7) begin
                  cnt_d   = '0;
                  we_d    = wel_q;
                  wdata_d = wel_q ? byte_in : wdata_q;
               end
               ST_STATUS: if (cnt_q == 5'd7) begin
                  cnt_d = '0;
                  tx_d  = status_byte(wel_q);
               end
               default: cnt_d = '0;
            endcase
         end
      end
   end

   assign spi_miso  = miso_q;
   assign mem_addr  = addr_q;
   assign mem_re    = re_q;
   assign mem_we    = we_q;
   assign mem_wdata = wdata_q;
   assign cmd_error = err_q;

endmodule

// File: tb/tb_spi_storage_responder.sv
// tb_spi_storage_responder: directed SPI transactions checked against a transaction-level storage model
module tb_spi_storage_responder;

   localparam int HALF = 8;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        spi_cs_n = 1'b1;
   logic        spi_sck = 1'b0;
   logic        spi_mosi = 1'b0;
   logic        spi_miso;
   logic [15:0] mem_addr;
   logic        mem_re;
   logic [7:0]  mem_rdata = 8'h00;
   logic        mem_we;
   logic [7:0]  mem_wdata;
   logic        cmd_error;

   logic [7:0]  mem [0:65535];
   logic [7:0]  model_mem [0:65535];
   logic        model_wel = 1'b0;
   logic [15:0] exp_re[$];
   logic [15:0] re_log[$];
   logic [23:0] exp_we[$];
   logic [23:0] we_log[$];
   logic [7:0]  txq[$];
   logic [7:0]  rxq[$];
   int          n_chk = 0;
   int          n_pass = 0;
   int          err_seen = 0;
   int          exp_err = 0;
   logic [7:0]  r;

   always #5 clk = ~clk;

   spi_storage_responder #(.ADDR_W(16), .SYNC_STAGES(2)) dut (
      .clk       (clk),
      .rst       (rst),
      .spi_cs_n  (spi_cs_n),
      .spi_sck   (spi_sck),
      .spi_mosi  (spi_mosi),
      .spi_miso  (spi_miso),
      .mem_addr  (mem_addr),
      .mem_re    (mem_re),
      .mem_rdata (mem_rdata),
      .mem_we    (mem_we),
      .mem_wdata (mem_wdata),
      .cmd_error (cmd_error)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   // External memory: read data one clock after the strobe
   always @(posedge clk) begin
      if (mem_re) mem_rdata <= mem[mem_addr];
      if (mem_we) mem[mem_addr] <= mem_wdata;
   end

   // Strobe checker against the model's expected memory traffic
   always @(negedge clk) begin
      if (rst) begin
         if (mem_re || mem_we) chk("re_we_exclusive", {31'd0, mem_re & mem_we}, 32'd0);
         if (mem_re) begin
            re_log.push_back(mem_addr);
            if (exp_re.size() == 0) begin
               n_chk++;
               $display("FAIL re_unexpected: got addr %0h expected no read", mem_addr);
            end else chk("re_addr", {16'd0, mem_addr}, {16'd0, exp_re.pop_front()});
         end
         if (mem_we) begin
            we_log.push_back({mem_addr, mem_wdata});
            if (exp_we.size() == 0) begin
               n_chk++;
               $display("FAIL we_unexpected: got %0h/%0h expected no write", mem_addr, mem_wdata);
            end else chk("we_addr_data", {8'd0, mem_addr, mem_wdata}, {8'd0, exp_we.pop_front()});
         end
         if (cmd_error) err_seen++;
      end
   end

   task automatic xbits(input int n, input logic [7:0] v, output logic [7:0] rb);
      rb = 8'h00;
      for (int i = 0; i < n; i++) begin
         spi_mosi = v[7-i];
         repeat (HALF) @(negedge clk);
         rb[7-i] = spi_miso;
         spi_sck = 1'b1;
         repeat (HALF) @(negedge clk);
         spi_sck = 1'b0;
      end
   endtask

   task automatic run_txn(input int pbits, input logic [7:0] pval);
      int n;
      logic [7:0] op;
      logic [15:0] a;
      logic [15:0] ad;
      logic [7:0] exp_rx[$];
      logic [7:0] rb;
      n = txq.size();
      op = txq[0];
      a = 16'h0000;
      for (int i = 0; i < n; i++) exp_rx.push_back(8'h00);
      if (n >= 4) a = {txq[2], txq[3]};
      case (op)
         8'h03: if (n >= 4) for (int k = 0; k <= n - 4; k++) begin
            ad = a + 16'(k);
            exp_re.push_back(ad);
            if (k < n - 4) exp_rx[4+k] = model_mem[ad];
         end
         8'h02: if (n >= 4 && model_wel) for (int k = 0; k < n - 4; k++) begin
            ad = a + 16'(k);
            exp_we.push_back({ad, txq[4+k]});
            model_mem[ad] = txq[4+k];
         end
         8'h05: for (int k = 1; k < n; k++) exp_rx[k] = {6'd0, model_wel, 1'b0};
         8'h04, 8'h06: ;
         default: exp_err++;
      endcase
      rxq.delete();
      spi_cs_n = 1'b0;
      repeat (HALF) @(negedge clk);
      for (int i = 0; i < n; i++) begin
         xbits(8, txq[i], rb);
         rxq.push_back(rb);
         chk($sformatf("miso_op%0h_byte%0d", op, i), {24'd0, rb}, {24'd0, exp_rx[i]});
      end
      if (pbits > 0) xbits(pbits, pval, rb);
      repeat (HALF) @(negedge clk);
      spi_cs_n = 1'b1;
      repeat (2 * HALF) @(negedge clk);
      if (op == 8'h06) model_wel = 1'b1;
      else if (op == 8'h04 || op == 8'h02) model_wel = 1'b0;
      chk("miso_idle", {31'd0, spi_miso}, 32'd0);
      chk("cmd_error_count", err_seen, exp_err);
      chk("re_outstanding", exp_re.size(), 32'd0);
      chk("we_outstanding", exp_we.size(), 32'd0);
   endtask

   initial begin
      for (int i = 0; i < 65536; i++) begin
         mem[i] = 8'h00;
         model_mem[i] = 8'h00;
      end
      mem[16'hFFFF] = 8'h11;
      mem[16'h0000] = 8'h22;
      model_mem[16'hFFFF] = 8'h11;
      model_mem[16'h0000] = 8'h22;
      #1 rst = 1'b0;
      repeat (3) @(negedge clk);
      chk("reset_outputs", {4'd0, spi_miso, mem_re, mem_we, cmd_error, mem_addr, mem_wdata}, 32'd0);
      rst = 1'b1;
      repeat (4) @(negedge clk);

      txq = '{8'h06};
      run_txn(0, 8'h00);
      txq = '{8'h02, 8'h00, 8'h00, 8'h10, 8'hA5, 8'h3C};
      run_txn(0, 8'h00);
      chk("we0_lit", {8'd0, we_log[0]}, 32'h0010A5);
      chk("we1_lit", {8'd0, we_log[1]}, 32'h00113C);
      txq = '{8'h05, 8'h00};
      run_txn(0, 8'h00);
      chk("rdsr_after_program_lit", {24'd0, rxq[1]}, 32'h00);

      txq = '{8'h02, 8'h00, 8'h02, 8'h00, 8'hDE, 8'hAD, 8'hBE};
      run_txn(0, 8'h00);
      chk("program_no_wren_lit", we_log.size(), 32'd2);

      txq = '{8'h03, 8'h00, 8'hFF, 8'hFF, 8'h00, 8'h00};
      run_txn(0, 8'h00);
      chk("read_wrap_b0_lit", {24'd0, rxq[4]}, 32'h11);
      chk("read_wrap_b1_lit", {24'd0, rxq[5]}, 32'h22);
      chk("read_re0_lit", {16'd0, re_log[0]}, 32'hFFFF);
      chk("read_re1_lit", {16'd0, re_log[1]}, 32'h0000);

      txq = '{8'h06};
      run_txn(0, 8'h00);
      txq = '{8'h05, 8'h00, 8'h00};
      run_txn(0, 8'h00);
      chk("rdsr_wel_b0_lit", {24'd0, rxq[1]}, 32'h02);
      chk("rdsr_wel_b1_lit", {24'd0, rxq[2]}, 32'h02);

      txq = '{8'h9F, 8'h00, 8'h00};
      run_txn(0, 8'h00);
      chk("bad_opcode_err_lit", err_seen, 32'd1);

      txq = '{8'h02, 8'h00, 8'h00, 8'h40};
      run_txn(5, 8'hF0);
      txq = '{8'h05, 8'h00};
      run_txn(0, 8'h00);
      chk("partial_write_wel_lit", {24'd0, rxq[1]}, 32'h00);
      chk("partial_write_no_we_lit", we_log.size(), 32'd2);

      txq = '{8'h06};
      run_txn(0, 8'h00);
      exp_re.push_back(16'h0010);
      exp_re.push_back(16'h0011);
      txq = '{8'h03, 8'h00, 8'h00, 8'h10, 8'h00};
      spi_cs_n = 1'b0;
      repeat (HALF) @(negedge clk);
      for (int i = 0; i < 5; i++) xbits(8, txq[i], r);
      chk("pre_reset_read_lit", {24'd0, r}, 32'hA5);
      rst = 1'b0;
      @(negedge clk);
      chk("reset_mid_read", {4'd0, spi_miso, mem_re, mem_we, cmd_error, mem_addr, mem_wdata}, 32'd0);
      chk("reset_re_drained", exp_re.size(), 32'd0);
      spi_cs_n = 1'b1;
      model_wel = 1'b0;
      repeat (4) @(negedge clk);
      rst = 1'b1;
      repeat (2 * HALF) @(negedge clk);
      txq = '{8'h05, 8'h00};
      run_txn(0, 8'h00);
      chk("wel_after_reset_lit", {24'd0, rxq[1]}, 32'h00);
      txq = '{8'h03, 8'h12, 8'h00, 8'h10, 8'h00, 8'h00};
      run_txn(0, 8'h00);
      chk("read_after_reset_b0_lit", {24'd0, rxq[4]}, 32'hA5);
      chk("read_after_reset_b1_lit", {24'd0, rxq[5]}, 32'h3C);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
